// File: rtl/svc_rv_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters and a walking clear after reset.
// Optional macro SVC_RV_BTB_BYPASS_EN forwards a same-cycle, same-index update into the lookup result.
module svc_rv_btb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            init_busy,
  input  logic            lookup_en,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_is_return,
  input  logic            btb_update_en,
  input  logic [XLEN-1:0] btb_update_pc,
  input  logic [XLEN-1:0] btb_update_target,
  input  logic            btb_update_taken,
  input  logic            btb_update_is_return
);

  localparam int unsigned IDX_W = $clog2(NENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NENTRIES - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_idx;

  logic             tbl_valid  [NENTRIES];
  logic [TAG_W-1:0] tbl_tag    [NENTRIES];
  logic [XLEN-1:0]  tbl_target [NENTRIES];
  logic [1:0]       tbl_ctr    [NENTRIES];
  logic             tbl_ret    [NENTRIES];

  logic [IDX_W-1:0] up_idx, lk_idx;
  logic [TAG_W-1:0] up_tag, lk_tag;
  logic             unused_pc_bits;

  assign up_idx = btb_update_pc[IDX_W+1:2];
  assign up_tag = btb_update_pc[XLEN-1:IDX_W+2];
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], btb_update_pc[1:0]};

  // Update read-modify-write: the entry image to be written this cycle
  logic             up_hit, wr_en;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  logic [1:0]       wr_ctr;
  logic             wr_ret;

  always_comb begin
    up_hit    = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
    wr_en     = 1'b0;
    wr_tag    = up_tag;
    wr_target = tbl_target[up_idx];
    wr_ctr    = tbl_ctr[up_idx];
    wr_ret    = tbl_ret[up_idx];
    if (rst_n && (state == ST_READY) && btb_update_en) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (btb_update_taken) begin
          wr_ctr    = (tbl_ctr[up_idx] == 2'd3) ? 2'd3 : tbl_ctr[up_idx] + 2'd1;
          wr_target = btb_update_target;
          wr_ret    = btb_update_is_return;
        end else begin
          wr_ctr    = (tbl_ctr[up_idx] == 2'd0) ? 2'd0 : tbl_ctr[up_idx] - 2'd1;
        end
      end else if (btb_update_taken) begin
        wr_en     = 1'b1;
        wr_target = btb_update_target;
        wr_ctr    = 2'b10;
        wr_ret    = btb_update_is_return;
      end
    end
  end

  // Lookup read port
  logic             rd_valid, rd_hit, rd_ret;
  logic [TAG_W-1:0] rd_tag;
  logic [XLEN-1:0]  rd_target;
  logic [1:0]       rd_ctr;

  always_comb begin
    rd_valid  = tbl_valid[lk_idx];
    rd_tag    = tbl_tag[lk_idx];
    rd_target = tbl_target[lk_idx];
    rd_ctr    = tbl_ctr[lk_idx];
    rd_ret    = tbl_ret[lk_idx];
`ifdef SVC_RV_BTB_BYPASS_EN
    if (wr_en && (up_idx == lk_idx)) begin
      rd_valid  = 1'b1;
      rd_tag    = wr_tag;
      rd_target = wr_target;
      rd_ctr    = wr_ctr;
      rd_ret    = wr_ret;
    end
`endif
    rd_hit = rd_valid && (rd_tag == lk_tag);
  end

  // Table storage: no reset so it maps to distributed RAM; valid is cleared by the init walk
  always_ff @(posedge clk) begin
    if (rst_n && (state == ST_INIT)) begin
      tbl_valid[init_idx] <= 1'b0;
    end else if (wr_en) begin
      tbl_valid[up_idx]  <= 1'b1;
      tbl_tag[up_idx]    <= wr_tag;
      tbl_target[up_idx] <= wr_target;
      tbl_ctr[up_idx]    <= wr_ctr;
      tbl_ret[up_idx]    <= wr_ret;
    end
  end

  // Control FSM with registered prediction outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_INIT;
      init_idx       <= '0;
      init_busy      <= 1'b1;
      pred_hit       <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= '0;
      pred_is_return <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (init_idx == LAST_IDX) begin
            state     <= ST_READY;
            init_busy <= 1'b0;
          end
          if (lookup_en) begin
            pred_hit       <= 1'b0;
            pred_taken     <= 1'b0;
            pred_target    <= '0;
            pred_is_return <= 1'b0;
          end
        end
        ST_READY: begin
          if (lookup_en) begin
            pred_hit       <= rd_hit;
            pred_taken     <= rd_hit && rd_ctr[1];
            pred_target    <= rd_target;
            pred_is_return <= rd_hit && rd_ret;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
